sm3_expnd_arb: RTL and testbench
================================

Name: sm3_expnd_arb

Overview:
- Two-requester message arbiter in front of sm3_expnd_core. It shares one expansion/compression pipeline between two independent padded-message sources.
- A grant is held for a whole message, from the first word to the lst word. It is released only after the expansion core signals its final round for that message.
- A compression context therefore never mixes two messages.
- Checks that each requester's lst word lands on a 512-bit block boundary.

Parameters:
- DW, 32, padded-message word width in bits (32 or 64).
- WPB, 512/DW, words per 512-bit block (derived; not overridable).
- CW, $clog2(WPB), width of the block word counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_d_i  in  DW  requester 0 padded data word
- req0_vld_i  in  1  requester 0 word valid
- req0_lst_i  in  1  requester 0 last word of message
- req0_rdy_o  out  1  requester 0 word accepted
- req1_d_i / req1_vld_i / req1_lst_i / req1_rdy_o  same as req0, for requester 1
- pad_otpt_d_o  out  DW  data to the expand core's pad_inpt_d_i
- pad_otpt_vld_o  out  1  to pad_inpt_vld_i
- pad_otpt_lst_o  out  1  to pad_inpt_lst_i
- pad_otpt_rdy_i  in  1  from pad_inpt_rdy_o
- expnd_otpt_vld_i  in  1  expand core output valid (monitor only)
- expnd_otpt_lst_i  in  1  expand core final round of message (monitor only)
- gnt_id_o  out  1  current/last owner (0 or 1)
- busy_o  out  1  a message is in flight (GRANT or DRAIN)
- err_misalign_o  out  1  sticky: lst word accepted when word count != WPB-1
- err_proto_o  out  1  sticky: expnd_otpt_vld_i & expnd_otpt_lst_i seen outside DRAIN

Behaviour:
- Reset values:
  - state=IDLE, rr_last=1 (so req0 wins first), wcnt=0, gnt_id_o=0.
  - busy_o=0, both errors 0, all rdy/vld/lst outputs 0, pad_otpt_d_o=0.
- Reset asserted mid-message aborts the message immediately; no drain is performed.
- FSM IDLE:
  - Sample req0_vld_i and req1_vld_i.
  - Only one valid: grant it.
  - Both valid: grant !rr_last.
  - On a grant, register gnt_id_o and go to GRANT next cycle. No word is passed during the IDLE cycle, so arbitration costs 1 cycle.
  - Neither valid: stay in IDLE.
- FSM GRANT:
  - Outputs are combinational from the granted requester: pad_otpt_d_o/vld_o/lst_o = reqN_*; reqN_rdy_o = pad_otpt_rdy_i.
  - The non-granted rdy is held 0.
  - Outputs are zero-latency (pure mux, no buffering); the data/lst mux is gated so pad_otpt_d_o=0 when the selected vld=0.
  - Handshake = pad_otpt_vld_o & pad_otpt_rdy_i.
  - Each handshake: wcnt = (wcnt==WPB-1) ? 0 : wcnt+1.
  - Handshake with lst=1:
    - If wcnt != WPB-1, set err_misalign_o.
    - Clear wcnt, set rr_last=gnt_id_o, go to DRAIN.
  - A requester dropping vld mid-message does not release the grant.
- FSM DRAIN:
  - All rdy outputs and pad_otpt_vld_o are 0.
  - On expnd_otpt_vld_i & expnd_otpt_lst_i, go to IDLE next cycle.
  - The next grant is therefore issued no earlier than 1 cycle after DRAIN exits (back-to-back messages pay 2 idle cycles).
- busy_o = 1 in GRANT and DRAIN.
- gnt_id_o holds its value through IDLE until the next grant.
- expnd_otpt_lst_i with vld while in IDLE or GRANT sets err_proto_o. The state is unaffected.
- Sticky errors clear only on rst.
- Simultaneous lst handshake and expnd lst in GRANT: the lst handshake wins and the FSM goes to DRAIN. err_proto_o is also set.

Test Plan:
- Single requester: req0 sends 16 words (DW=32) with lst on word 16, core rdy held 1.
  - Required: 16 handshakes in 16 consecutive cycles after 1 IDLE cycle; gnt_id_o=0; busy_o=1.
  - DRAIN holds until expnd lst is pulsed; busy_o falls 1 cycle after that pulse.
- Both requesters valid in the same cycle after reset.
  - Required: req0 granted first; req1 granted after req0's drain completes.
  - Repeated contention then alternates 0,1,0,1.
- Backpressure: pad_otpt_rdy_i toggled every other cycle for a 32-word (2-block) message from req1.
  - Required: exactly 32 handshakes; req0_rdy_o stays 0 throughout; no err_misalign_o.
- Misaligned lst: req0 asserts lst on word 10.
  - Required: err_misalign_o=1 from the next cycle; FSM enters DRAIN; flag persists across subsequent messages until rst.
- Protocol error: pulse expnd_otpt_vld_i and expnd_otpt_lst_i while in GRANT at word 5.
  - Required: err_proto_o=1; transfer continues; no early release.
- Mid-message reset: assert rst for 1 cycle at word 7 of req1.
  - Required: the next cycle shows all outputs at reset values and state=IDLE.
  - The next contention grants req0.

Source files
------------

// File: rtl/sm3_expnd_arb.sv
// Two-requester arbiter in front of sm3_expnd_core: holds a grant for a whole message and
// releases it only after the core reports the final round; the datapath is a zero-latency mux.
module sm3_expnd_arb #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] req0_d_i,
    input  logic          req0_vld_i,
    input  logic          req0_lst_i,
    output logic          req0_rdy_o,
    input  logic [DW-1:0] req1_d_i,
    input  logic          req1_vld_i,
    input  logic          req1_lst_i,
    output logic          req1_rdy_o,
    output logic [DW-1:0] pad_otpt_d_o,
    output logic          pad_otpt_vld_o,
    output logic          pad_otpt_lst_o,
    input  logic          pad_otpt_rdy_i,
    input  logic          expnd_otpt_vld_i,
    input  logic          expnd_otpt_lst_i,
    output logic          gnt_id_o,
    output logic          busy_o,
    output logic          err_misalign_o,
    output logic          err_proto_o
);
    localparam int WPB = 512 / DW;
    localparam int CW  = $clog2(WPB);
    localparam logic [CW-1:0] WMAX = CW'(WPB - 1);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t        state;
    logic          rr_last;
    logic [CW-1:0] wcnt;

    logic          in_grant;
    logic          sel_vld;
    logic          sel_lst;
    logic [DW-1:0] sel_d;
    logic          hs;
    logic          expnd_fin;

    assign in_grant  = (state == GRANT);
    assign sel_vld   = gnt_id_o ? req1_vld_i : req0_vld_i;
    assign sel_lst   = gnt_id_o ? req1_lst_i : req0_lst_i;
    assign sel_d     = gnt_id_o ? req1_d_i   : req0_d_i;
    assign expnd_fin = expnd_otpt_vld_i & expnd_otpt_lst_i;

    // Data and lst are gated by valid so idle cycles present an all-zero word.
    assign pad_otpt_vld_o = in_grant & sel_vld;
    assign pad_otpt_lst_o = pad_otpt_vld_o & sel_lst;
    assign pad_otpt_d_o   = pad_otpt_vld_o ? sel_d : '0;
    assign req0_rdy_o     = in_grant & ~gnt_id_o & pad_otpt_rdy_i;
    assign req1_rdy_o     = in_grant &  gnt_id_o & pad_otpt_rdy_i;
    assign hs             = pad_otpt_vld_o & pad_otpt_rdy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_last        <= 1'b1;
            wcnt           <= '0;
            gnt_id_o       <= 1'b0;
            busy_o         <= 1'b0;
            err_misalign_o <= 1'b0;
            err_proto_o    <= 1'b0;
        end else begin
            if (expnd_fin && state != DRAIN) begin
                err_proto_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req0_vld_i || req1_vld_i) begin
                        gnt_id_o <= (req0_vld_i && req1_vld_i) ? ~rr_last : req1_vld_i;
                        state    <= GRANT;
                        busy_o   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (hs) begin
                        if (sel_lst) begin
                            if (wcnt != WMAX) begin
                                err_misalign_o <= 1'b1;
                            end
                            wcnt    <= '0;
                            rr_last <= gnt_id_o;
                            state   <= DRAIN;
                        end else begin
                            wcnt <= (wcnt == WMAX) ? '0 : wcnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (expnd_fin) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm3_expnd_arb.sv
// Bench for sm3_expnd_arb: table of message scenarios plus hand-written drain, protocol-error
// and mid-message reset sequences; accepted words are checked against per-requester queues.
module tb_sm3_expnd_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req0_d = '0, req1_d = '0;
    logic        req0_vld = 1'b0, req0_lst = 1'b0, req1_vld = 1'b0, req1_lst = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [31:0] pad_d;
    logic        pad_vld, pad_lst;
    logic        pad_rdy = 1'b1;
    logic        expnd_v = 1'b0, expnd_l = 1'b0;
    logic        gnt_id, busy, err_mis, err_proto;

    always #5 clk = ~clk;

    sm3_expnd_arb #(.DW(32)) dut (
        .clk(clk), .rst(rst),
        .req0_d_i(req0_d), .req0_vld_i(req0_vld), .req0_lst_i(req0_lst), .req0_rdy_o(req0_rdy),
        .req1_d_i(req1_d), .req1_vld_i(req1_vld), .req1_lst_i(req1_lst), .req1_rdy_o(req1_rdy),
        .pad_otpt_d_o(pad_d), .pad_otpt_vld_o(pad_vld), .pad_otpt_lst_o(pad_lst),
        .pad_otpt_rdy_i(pad_rdy),
        .expnd_otpt_vld_i(expnd_v), .expnd_otpt_lst_i(expnd_l),
        .gnt_id_o(gnt_id), .busy_o(busy), .err_misalign_o(err_mis), .err_proto_o(err_proto)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int glog[$];
    int hs_cnt = 0, first_hs = 0, last_hs = 0;
    bit new_msg = 1'b1;
    bit auto_drain = 1'b0;
    bit tog_mode = 1'b0;
    bit abort = 1'b0;
    int drain_cnt = 0;

    typedef struct {
        bit do_rst;
        int nw0;
        int nw1;
        bit tog;
        int exp_first;
        int exp_nmsg;
        bit exp_mis;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Core-side ready: held high, or toggled every cycle for backpressure runs.
    always @(posedge clk) begin
        #1;
        if (tog_mode) pad_rdy = ~pad_rdy;
        else          pad_rdy = 1'b1;
    end

    // Stand-in for the expansion core: final-round pulse two cycles after a lst handshake.
    always @(posedge clk) begin
        #1;
        if (auto_drain) begin
            if (drain_cnt > 0) begin
                drain_cnt = drain_cnt - 1;
                expnd_v   = (drain_cnt == 0);
                expnd_l   = (drain_cnt == 0);
            end else begin
                expnd_v = 1'b0;
                expnd_l = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : mon
        logic [32:0] e;
        if (!rst) begin
            check("rdy_excl", {63'd0, req0_rdy & req1_rdy}, 64'd0);
            if (req0_rdy) check("rdy0_owner", {61'd0, busy, gnt_id, pad_rdy}, 64'b101);
            if (req1_rdy) check("rdy1_owner", {61'd0, busy, gnt_id, pad_rdy}, 64'b111);
            if (!busy) check("idle_vld", {63'd0, pad_vld}, 64'd0);
            if (pad_vld && pad_rdy) begin
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
                if (new_msg) begin
                    glog.push_back(int'(gnt_id));
                    new_msg = 1'b0;
                end
                if ((gnt_id ? q1.size() : q0.size()) == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: got word %0h from owner %0d, required none", pad_d, gnt_id);
                end else begin
                    e = gnt_id ? q1.pop_front() : q0.pop_front();
                    check("sb_word", {31'd0, pad_lst, pad_d}, {31'd0, e});
                end
                if (pad_lst) begin
                    new_msg = 1'b1;
                    if (auto_drain) drain_cnt = 2;
                end
            end
        end
    end

    task automatic drive(input int id, input logic v, input logic [31:0] d, input logic l);
        if (id == 0) begin
            req0_vld = v; req0_d = d; req0_lst = l;
        end else begin
            req1_vld = v; req1_d = d; req1_lst = l;
        end
    endtask

    // Called at posedge+1; pushes the whole message to the scoreboard, then offers words in order.
    task automatic send(input int id, input int nw, input logic [31:0] base);
        int i = 0;
        int guard = 0;
        logic take;
        logic [32:0] w;
        for (int k = 0; k < nw; k++) begin
            w = {(k == nw - 1), base + 32'(k)};
            if (id == 0) q0.push_back(w);
            else         q1.push_back(w);
        end
        while (i < nw && !abort && guard < 3000) begin
            drive(id, 1'b1, base + 32'(i), (i == nw - 1));
            @(negedge clk);
            take = (id != 0) ? req1_rdy : req0_rdy;
            @(posedge clk);
            #1;
            if (take) i++;
            guard++;
        end
        drive(id, 1'b0, '0, 1'b0);
        if (guard >= 3000 && !abort) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: requester %0d got %0d of %0d words accepted", id, i, nw);
        end
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        @(negedge clk);
        while (busy && g < 500) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_drain_done"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pad_vld"}, {63'd0, pad_vld}, 64'd0);
        check({tag, "_pad_lst"}, {63'd0, pad_lst}, 64'd0);
        check({tag, "_pad_d"}, {32'd0, pad_d}, 64'd0);
        check({tag, "_rdy0"}, {63'd0, req0_rdy}, 64'd0);
        check({tag, "_rdy1"}, {63'd0, req1_rdy}, 64'd0);
        check({tag, "_gnt"}, {63'd0, gnt_id}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_err_mis"}, {63'd0, err_mis}, 64'd0);
        check({tag, "_err_proto"}, {63'd0, err_proto}, 64'd0);
    endtask

    task automatic flush_sb();
        q0.delete();
        q1.delete();
        glog.delete();
        new_msg = 1'b1;
        drain_cnt = 0;
        hs_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int start;
        int g;
        // do_rst, words from req0, words from req1, toggle rdy, first owner, messages, misalign
        tbl[0] = '{1'b1, 16, 16, 1'b0, 0, 2, 1'b0};
        tbl[1] = '{1'b0, 16, 16, 1'b0, 0, 2, 1'b0};
        tbl[2] = '{1'b0,  0, 32, 1'b1, 1, 1, 1'b0};
        tbl[3] = '{1'b0, 10,  0, 1'b0, 0, 1, 1'b1};
        tbl[4] = '{1'b0,  0, 16, 1'b0, 1, 1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // Single 16-word message, drained by hand.
        @(posedge clk);
        #1;
        flush_sb();
        start = cyc;
        send(0, 16, 32'hA000_0000);
        check("h1_hs_cnt", 64'(hs_cnt), 64'd16);
        check("h1_arb_cycle", 64'(first_hs - start), 64'd1);
        check("h1_burst", 64'(last_hs - first_hs), 64'd15);
        check("h1_owner", 64'(glog.size() > 0 ? glog[0] : 99), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("h1_drain_busy", {63'd0, busy}, 64'd1);
        check("h1_drain_gnt", {63'd0, gnt_id}, 64'd0);
        check("h1_drain_vld", {63'd0, pad_vld}, 64'd0);
        @(posedge clk);
        #1;
        expnd_v = 1'b1; expnd_l = 1'b1;
        @(negedge clk);
        check("h1_busy_at_pulse", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        expnd_v = 1'b0; expnd_l = 1'b0;
        @(negedge clk);
        check("h1_busy_after", {63'd0, busy}, 64'd0);
        check("h1_err_proto", {63'd0, err_proto}, 64'd0);
        @(posedge clk);
        #1;

        auto_drain = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = tbl[i];
            if (v.do_rst) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            flush_sb();
            tog_mode = v.tog;
            fork
                begin
                    if (v.nw0 > 0) send(0, v.nw0, 32'hA100_0000 + 32'(i << 8));
                end
                begin
                    if (v.nw1 > 0) send(1, v.nw1, 32'hB100_0000 + 32'(i << 8));
                end
            join
            wait_idle($sformatf("t%0d", i));
            tog_mode = 1'b0;
            check($sformatf("t%0d_hs_cnt", i), 64'(hs_cnt), 64'(v.nw0 + v.nw1));
            check($sformatf("t%0d_nmsg", i), 64'(glog.size()), 64'(v.exp_nmsg));
            check($sformatf("t%0d_first", i), 64'(glog.size() > 0 ? glog[0] : 99), 64'(v.exp_first));
            if (v.exp_nmsg == 2)
                check($sformatf("t%0d_second", i), 64'(glog.size() > 1 ? glog[1] : 99),
                      64'(1 - v.exp_first));
            check($sformatf("t%0d_err_mis", i), {63'd0, err_mis}, 64'(v.exp_mis));
            check($sformatf("t%0d_sb_left", i), 64'(q0.size() + q1.size()), 64'd0);
        end

        // Final-round pulse from the core while still in GRANT.
        auto_drain = 1'b0;
        flush_sb();
        check("h3_proto_pre", {63'd0, err_proto}, 64'd0);
        g = 0;
        fork
            send(0, 16, 32'hC000_0000);
            begin
                while (hs_cnt < 5 && g < 200) begin
                    @(posedge clk);
                    g++;
                end
                #1;
                expnd_v = 1'b1; expnd_l = 1'b1;
                @(posedge clk);
                #1;
                expnd_v = 1'b0; expnd_l = 1'b0;
            end
        join
        check("h3_wait", 64'(g < 200), 64'd1);
        @(negedge clk);
        check("h3_err_proto", {63'd0, err_proto}, 64'd1);
        check("h3_hs_cnt", 64'(hs_cnt), 64'd16);
        check("h3_no_gap", 64'(last_hs - first_hs), 64'd15);
        check("h3_still_drain", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        expnd_v = 1'b1; expnd_l = 1'b1;
        @(posedge clk);
        #1;
        expnd_v = 1'b0; expnd_l = 1'b0;
        @(negedge clk);
        check("h3_released", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // Reset at word 7 of a req1 message, then contention must favour req0.
        flush_sb();
        g = 0;
        fork
            send(1, 32, 32'hD000_0000);
            begin
                while (hs_cnt < 7 && g < 200) begin
                    @(posedge clk);
                    g++;
                end
                #2;
                rst = 1'b1;
                abort = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
            end
        join
        check("h4_wait", 64'(g < 200), 64'd1);
        @(negedge clk);
        check_reset_vals("h4");
        @(posedge clk);
        #1;
        abort = 1'b0;
        flush_sb();
        auto_drain = 1'b1;
        fork
            send(0, 16, 32'hE000_0000);
            send(1, 16, 32'hF000_0000);
        join
        wait_idle("h4");
        check("h4_first", 64'(glog.size() > 0 ? glog[0] : 99), 64'd0);
        check("h4_second", 64'(glog.size() > 1 ? glog[1] : 99), 64'd1);
        check("h4_hs_cnt", 64'(hs_cnt), 64'd32);
        check("h4_err_mis", {63'd0, err_mis}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
